sram_1rw1r_param: RTL and testbench
===================================

SRAM_1RW1R_PARAM -- requirements
Module: sram_1rw1r_param

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, address width of both ports.
REQ-003 The block SHALL have parameter RAM_DEPTH, default 1<<ADDR_WIDTH, number of implemented words (legal range 1 to 1<<ADDR_WIDTH).
REQ-004 The block SHALL have parameter LANE_WIDTH, default 8, bits per write-mask lane; DATA_WIDTH SHALL be an integer multiple of it, and NUM_WMASKS = DATA_WIDTH/LANE_WIDTH.
REQ-005 The block SHALL have parameter READ_LATENCY, default 1, read latency in cycles (legal values 1 or 2).
REQ-006 The block SHALL have parameter BYPASS, default 1; 1 forwards same-cycle port-0 write data to port 1, 0 returns old data.
REQ-007 Ports SHALL be as follows (one per line: name, direction, width, meaning):
- clk0  in  1  single clock for both ports; rising edge active
- rst0  in  1  reset; asynchronous assert, active-high
- csb0  in  1  port 0 chip select, active low
- web0  in  1  port 0 write enable, active low
- wmask0  in  NUM_WMASKS  per-lane write enable, active high
- addr0  in  ADDR_WIDTH  port 0 address
- din0  in  DATA_WIDTH  port 0 write data
- dout0  out  DATA_WIDTH  port 0 read data
- dout0_valid  out  1  port 0 read data valid, one-cycle pulse per read
- csb1  in  1  port 1 chip select, active low
- addr1  in  ADDR_WIDTH  port 1 read address
- dout1  out  DATA_WIDTH  port 1 read data
- dout1_valid  out  1  port 1 read data valid, one-cycle pulse per read
- coll_cnt  out  16  saturating count of same-address write/read collisions

Function
REQ-008 All inputs SHALL be sampled on the rising edge of clk0; the cycle in which a request is presented is cycle 0.
REQ-009 A port-0 write (csb0=0, web0=0) SHALL update exactly the lanes i with wmask0[i]=1; lanes with wmask0[i]=0 SHALL keep their contents.
REQ-010 A port-0 read (csb0=0, web0=1) SHALL present mem[addr0] on dout0 with dout0_valid=1 in cycle READ_LATENCY.
REQ-011 A port-1 read (csb1=0) SHALL present mem[addr1] on dout1 with dout1_valid=1 in cycle READ_LATENCY.
REQ-012 Reads and writes SHALL be fully pipelined: one new request per port per cycle, with results returned in request order.
REQ-013 While a port's valid output is 0, its dout SHALL hold its last valid value.
REQ-014 A port-0 write SHALL NOT assert dout0_valid and SHALL NOT change dout0.
REQ-015 Collision condition: in the same cycle, a port-0 write with nonzero wmask0 and a port-1 read with addr0==addr1.
REQ-016 On a collision with BYPASS=1, dout1 SHALL return the enabled lanes from din0 and the other lanes from the old word.
REQ-017 On a collision with BYPASS=0, dout1 SHALL return the pre-write word.
REQ-018 On every collision, coll_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-019 Any write with addr0 >= RAM_DEPTH SHALL be ignored.
REQ-020 Any read with address >= RAM_DEPTH SHALL return all-zero data with valid asserted.
REQ-021 A write with wmask0 all zero SHALL change no memory and SHALL NOT count as a collision.
REQ-022 Port-1 read data in cycle 1 or later SHALL reflect every write completed in cycle 0 or earlier.

Reset
REQ-023 While rst0=1: dout0, dout1 and coll_cnt SHALL be 0, dout0_valid and dout1_valid SHALL be 0, and all read pipeline stages SHALL be cleared.
REQ-024 Requests presented while rst0=1 SHALL be ignored: no write, no valid, no count.
REQ-025 Reads in flight when rst0 asserts SHALL be dropped and never produce a valid.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 After rst0 deasserts, the first rising edge of clk0 SHALL accept requests normally.

Verification
REQ-028 Full-word write: write 0xDEADBEEF to address 5, then read address 5 on port 0 -> dout0=0xDEADBEEF with dout0_valid in cycle READ_LATENCY; repeat for READ_LATENCY=2.
REQ-029 Masked write: write 0xFFFFFFFF to address 7, then write 0x11223344 with wmask0=4'b0101 -> a port-1 read of address 7 returns 0xFF22FF44.
REQ-030 Collision: address 3 holds 0xAAAAAAAA; in the same cycle, port 0 writes 0x55555555 with wmask0=4'b0011 and port 1 reads address 3 -> dout1=0xAAAA5555 when BYPASS=1 and 0xAAAAAAAA when BYPASS=0; coll_cnt=1.
REQ-031 Boundary: with RAM_DEPTH=1000, write to address 1010 then read address 1010 -> dout=0 with valid; addresses 0 and 999 round-trip correctly; back-to-back reads every cycle return in request order.
REQ-032 Reset mid-operation: issue reads on both ports, then assert rst0 in the next cycle -> no valid pulse appears, all outputs are 0, and contents written before reset read back unchanged after reset.
REQ-033 Saturation: force 65540 collisions -> coll_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/sram_1rw1r_param.sv
// sram_1rw1r_param: one write/read port plus one read-only port SRAM model
// with per-lane write masks, 1- or 2-cycle read latency, optional
// write-to-read bypass on same-address collisions and a collision counter.
module sram_1rw1r_param #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int unsigned LANE_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned BYPASS       = 1,
    localparam int unsigned NUM_WMASKS  = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic [15:0]           coll_cnt
);

    localparam int unsigned MEM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Storage array; contents survive reset
    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    // Request decode
    logic                  wr_req_c;
    logic                  rd0_req_c;
    logic                  rd1_req_c;
    logic                  addr0_ok_c;
    logic                  addr1_ok_c;
    logic                  coll_c;
    logic                  mem_we_c;
    logic [DATA_WIDTH-1:0] wbits_c;
    logic [DATA_WIDTH-1:0] old0_word_c;
    logic [DATA_WIDTH-1:0] old1_word_c;
    logic [DATA_WIDTH-1:0] rd1_word_c;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    // Second read stage (only used when READ_LATENCY == 2)
    logic                  rd0_v1_q, rd0_v1_d;
    logic [DATA_WIDTH-1:0] rd0_data1_q, rd0_data1_d;
    logic                  rd1_v1_q, rd1_v1_d;
    logic [DATA_WIDTH-1:0] rd1_data1_q, rd1_data1_d;

    // Output registers
    logic                  dout0_valid_q, dout0_valid_d;
    logic [DATA_WIDTH-1:0] dout0_q, dout0_d;
    logic                  dout1_valid_q, dout1_valid_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic [15:0]           coll_cnt_q, coll_cnt_d;

    // Decode requests, detect collisions and expand the lane mask to bits
    always_comb begin
        wr_req_c   = !csb0 && !web0;
        rd0_req_c  = !csb0 && web0;
        rd1_req_c  = !csb1;
        addr0_ok_c = {1'b0, addr0} < DEPTH_L;
        addr1_ok_c = {1'b0, addr1} < DEPTH_L;
        coll_c     = wr_req_c && (|wmask0) && rd1_req_c && (addr0 == addr1);
        mem_we_c   = wr_req_c && (|wmask0) && addr0_ok_c && !rst0;
        wbits_c    = '0;
        for (int i = 0; i < int'(NUM_WMASKS); i++) begin
            wbits_c[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[i]}};
        end
    end

    // Pre-write array reads; out-of-range addresses read as zero
    always_comb begin
        old0_word_c = '0;
        old1_word_c = '0;
        if (addr0_ok_c) begin
            old0_word_c = mem_q[MEM_AW'(addr0)];
        end
        if (addr1_ok_c) begin
            old1_word_c = mem_q[MEM_AW'(addr1)];
        end
    end

    // Merge write lanes; port 1 sees merged word on a bypassed collision
    always_comb begin
        mem_wdata_d = (din0 & wbits_c) | (old0_word_c & ~wbits_c);
        rd1_word_c  = old1_word_c;
        if ((BYPASS != 0) && coll_c && addr1_ok_c) begin
            rd1_word_c = (din0 & wbits_c) | (old1_word_c & ~wbits_c);
        end
    end

    // Array write port
    always_ff @(posedge clk0) begin
        if (mem_we_c) begin
            mem_q[MEM_AW'(addr0)] <= mem_wdata_d;
        end
    end

    // Next-state for the read pipeline, held outputs and collision counter
    always_comb begin
        rd0_v1_d      = rd0_req_c;
        rd0_data1_d   = old0_word_c;
        rd1_v1_d      = rd1_req_c;
        rd1_data1_d   = rd1_word_c;
        dout0_valid_d = 1'b0;
        dout0_d       = dout0_q;
        dout1_valid_d = 1'b0;
        dout1_d       = dout1_q;
        coll_cnt_d    = coll_cnt_q;
        if (READ_LATENCY == 1) begin
            dout0_valid_d = rd0_req_c;
            dout1_valid_d = rd1_req_c;
            if (rd0_req_c) begin
                dout0_d = old0_word_c;
            end
            if (rd1_req_c) begin
                dout1_d = rd1_word_c;
            end
        end else begin
            dout0_valid_d = rd0_v1_q;
            dout1_valid_d = rd1_v1_q;
            if (rd0_v1_q) begin
                dout0_d = rd0_data1_q;
            end
            if (rd1_v1_q) begin
                dout1_d = rd1_data1_q;
            end
        end
        if (coll_c && (coll_cnt_q != CNT_MAX)) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end
    end

    // Pipeline and output registers; reset drops in-flight reads
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rd0_v1_q      <= 1'b0;
            rd0_data1_q   <= '0;
            rd1_v1_q      <= 1'b0;
            rd1_data1_q   <= '0;
            dout0_valid_q <= 1'b0;
            dout0_q       <= '0;
            dout1_valid_q <= 1'b0;
            dout1_q       <= '0;
            coll_cnt_q    <= '0;
        end else begin
            rd0_v1_q      <= rd0_v1_d;
            rd0_data1_q   <= rd0_data1_d;
            rd1_v1_q      <= rd1_v1_d;
            rd1_data1_q   <= rd1_data1_d;
            dout0_valid_q <= dout0_valid_d;
            dout0_q       <= dout0_d;
            dout1_valid_q <= dout1_valid_d;
            dout1_q       <= dout1_d;
            coll_cnt_q    <= coll_cnt_d;
        end
    end

    assign dout0       = dout0_q;
    assign dout0_valid = dout0_valid_q;
    assign dout1       = dout1_q;
    assign dout1_valid = dout1_valid_q;
    assign coll_cnt    = coll_cnt_q;

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: two instances share stimulus (latency 1 with
// bypass, latency 2 without), checked against an array/queue reference model.
module tb_sram_1rw1r_param;

    localparam int DEPTH = 1000;

    logic        clk0 = 1'b0;
    logic        rst0;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [9:0]  addr0, addr1;
    logic [31:0] din0;

    logic [31:0] a_dout0, a_dout1, b_dout0, b_dout1;
    logic        a_v0, a_v1, b_v0, b_v1;
    logic [15:0] a_cnt, b_cnt;

    always #5 clk0 = ~clk0;

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(DEPTH),
        .LANE_WIDTH(8), .READ_LATENCY(1), .BYPASS(1)) u_a (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(a_dout0), .dout0_valid(a_v0),
        .csb1(csb1), .addr1(addr1), .dout1(a_dout1), .dout1_valid(a_v1),
        .coll_cnt(a_cnt));

    sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .RAM_DEPTH(DEPTH),
        .LANE_WIDTH(8), .READ_LATENCY(2), .BYPASS(0)) u_b (
        .clk0(clk0), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(b_dout0), .dout0_valid(b_v0),
        .csb1(csb1), .addr1(addr1), .dout1(b_dout1), .dout1_valid(b_v1),
        .coll_cnt(b_cnt));

    typedef struct {
        logic        rst;
        logic        csb0;
        logic        web0;
        logic [3:0]  wm;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        csb1;
        logic [9:0]  a1;
        logic        use_tab;
        logic [31:0] t0;
        logic [31:0] t1b;
        logic [31:0] t1n;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    // Reference state: memory image, expected results per output, counter
    logic [31:0] ref_mem [DEPTH];
    pend_t       pq [4][$];
    logic [31:0] last_d [4];
    logic [15:0] ref_cnt;
    int          lat [4] = '{1, 1, 2, 2};
    int          edge_n = 0;
    int          n_vec = 0;
    int          n_mis = 0;

    function automatic vec_t mk(input logic rst, input logic c0, input logic w0,
                                input logic [3:0] wm, input logic [9:0] a0,
                                input logic [31:0] d0, input logic c1,
                                input logic [9:0] a1, input logic ut,
                                input logic [31:0] t0, input logic [31:0] t1b,
                                input logic [31:0] t1n);
        vec_t v;
        v.rst = rst; v.csb0 = c0; v.web0 = w0; v.wm = wm; v.a0 = a0; v.d0 = d0;
        v.csb1 = c1; v.a1 = a1; v.use_tab = ut; v.t0 = t0; v.t1b = t1b; v.t1n = t1n;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s @edge %0d: got %h, required %h", nm, edge_n, act, exp);
        end
    endtask

    task automatic check_port(input int k, input logic v, input logic [31:0] d, input string nm);
        logic        ev;
        logic [31:0] ed;
        ev = 1'b0;
        ed = last_d[k];
        if (pq[k].size() > 0 && pq[k][0].due == edge_n) begin
            ev = 1'b1;
            ed = pq[k][0].data;
            last_d[k] = ed;
            void'(pq[k].pop_front());
        end
        cmp({nm, "_valid"}, 32'(v), 32'(ev));
        cmp(nm, d, ed);
    endtask

    task automatic push(input int k, input logic [31:0] data);
        pend_t e;
        e.due  = edge_n + lat[k] - 1;
        e.data = data;
        pq[k].push_back(e);
    endtask

    // Drive one cycle, advance the model at the edge, check just after it
    task automatic apply(input vec_t v);
        logic [31:0] old0, old1, bits, merged;
        logic        wr, rd0, rd1, coll;
        @(negedge clk0);
        rst0 = v.rst; csb0 = v.csb0; web0 = v.web0; wmask0 = v.wm;
        addr0 = v.a0; din0 = v.d0; csb1 = v.csb1; addr1 = v.a1;
        @(posedge clk0);
        if (v.rst) begin
            for (int k = 0; k < 4; k++) begin
                pq[k].delete();
                last_d[k] = 32'd0;
            end
            ref_cnt = 16'd0;
        end else begin
            wr   = !v.csb0 && !v.web0;
            rd0  = !v.csb0 && v.web0;
            rd1  = !v.csb1;
            old0 = (int'(v.a0) < DEPTH) ? ref_mem[v.a0] : 32'd0;
            old1 = (int'(v.a1) < DEPTH) ? ref_mem[v.a1] : 32'd0;
            bits = 32'd0;
            for (int i = 0; i < 4; i++) if (v.wm[i]) bits[i*8 +: 8] = 8'hFF;
            coll   = wr && (v.wm != 4'd0) && rd1 && (v.a0 == v.a1);
            merged = (coll && int'(v.a1) < DEPTH) ? ((v.d0 & bits) | (old1 & ~bits)) : old1;
            if (rd0) begin
                push(0, v.use_tab ? v.t0 : old0);
                push(2, v.use_tab ? v.t0 : old0);
            end
            if (rd1) begin
                push(1, v.use_tab ? v.t1b : merged);
                push(3, v.use_tab ? v.t1n : old1);
            end
            if (wr && int'(v.a0) < DEPTH) ref_mem[v.a0] = (v.d0 & bits) | (old0 & ~bits);
            if (coll && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
        end
        #1;
        check_port(0, a_v0, a_dout0, "a_dout0");
        check_port(1, a_v1, a_dout1, "a_dout1");
        check_port(2, b_v0, b_dout0, "b_dout0");
        check_port(3, b_v1, b_dout1, "b_dout1");
        cmp("a_coll_cnt", 32'(a_cnt), 32'(ref_cnt));
        cmp("b_coll_cnt", 32'(b_cnt), 32'(ref_cnt));
        edge_n++;
    endtask

    initial begin
        vec_t tab[$];
        vec_t v;
        rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
        wmask0 = 4'd0; addr0 = 10'd0; addr1 = 10'd0; din0 = 32'd0;
        ref_cnt = 16'd0;
        for (int k = 0; k < 4; k++) last_d[k] = 32'd0;

        // Reset state, with requests that must be ignored
        for (int i = 0; i < 3; i++)
            apply(mk(1'b1, 1'b0, 1'b1, 4'hF, 10'd1, 32'h0, 1'b0, 10'd1, 1'b0, 0, 0, 0));

        // Fill every implemented word so later reads are defined
        for (int i = 0; i < DEPTH; i++)
            apply(mk(1'b0, 1'b0, 1'b0, 4'hF, 10'(i), $urandom, 1'b1, 10'd0, 1'b0, 0, 0, 0));

        // Directed vectors: rst csb0 web0 wm a0 d0 csb1 a1 use_tab t0 t1(byp) t1(no byp)
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd5,    32'hDEADBEEF, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd5,    32'h0,        1, 10'd0,   1, 32'hDEADBEEF, 0, 0));
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd7,    32'hFFFFFFFF, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 4'h5, 10'd7,    32'h11223344, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 1, 1, 4'h0, 10'd0,    32'h0,        0, 10'd7,   1, 0, 32'hFF22FF44, 32'hFF22FF44));
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd3,    32'hAAAAAAAA, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 4'h3, 10'd3,    32'h55555555, 0, 10'd3,   1, 0, 32'hAAAA5555, 32'hAAAAAAAA));
        tab.push_back(mk(0, 1, 1, 4'h0, 10'd0,    32'h0,        0, 10'd3,   1, 0, 32'hAAAA5555, 32'hAAAA5555));
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd1010, 32'h12345678, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd1010, 32'h0,        0, 10'd1010,1, 32'h0, 32'h0, 32'h0));
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd0,    32'h0BADF00D, 1, 10'd0,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 0, 4'hF, 10'd999,  32'hCAFEBABE, 0, 10'd0,   1, 0, 32'h0BADF00D, 32'h0BADF00D));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd999,  32'h0,        0, 10'd999, 1, 32'hCAFEBABE, 32'hCAFEBABE, 32'hCAFEBABE));
        tab.push_back(mk(0, 0, 0, 4'h0, 10'd999,  32'h0,        0, 10'd999, 1, 0, 32'hCAFEBABE, 32'hCAFEBABE));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd0,    32'h0,        0, 10'd999, 1, 32'h0BADF00D, 32'hCAFEBABE, 32'hCAFEBABE));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd999,  32'h0,        0, 10'd0,   1, 32'hCAFEBABE, 32'h0BADF00D, 32'h0BADF00D));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd5,    32'h0,        0, 10'd7,   1, 32'hDEADBEEF, 32'hFF22FF44, 32'hFF22FF44));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd7,    32'h0,        0, 10'd5,   1, 32'hFF22FF44, 32'hDEADBEEF, 32'hDEADBEEF));
        // Reset right after reads on both ports; the write during reset is dropped
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd5,    32'h0,        0, 10'd7,   1, 32'hDEADBEEF, 32'hFF22FF44, 32'hFF22FF44));
        tab.push_back(mk(1, 0, 0, 4'hF, 10'd5,    32'h0,        0, 10'd5,   0, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 4'h0, 10'd7,    32'h0,        0, 10'd3,   0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd7,    32'h0,        0, 10'd5,   1, 32'hFF22FF44, 32'hDEADBEEF, 32'hDEADBEEF));
        tab.push_back(mk(0, 0, 1, 4'h0, 10'd3,    32'h0,        1, 10'd0,   1, 32'hAAAA5555, 0, 0));
        for (int i = 0; i < tab.size(); i++) apply(tab[i]);

        // Counter saturation through repeated collisions
        for (int i = 0; i < 65540; i++)
            apply(mk(1'b0, 1'b0, 1'b0, 4'h1, 10'd2, $urandom, 1'b0, 10'd2, 1'b0, 0, 0, 0));
        cmp("a_coll_sat", 32'(a_cnt), 32'h0000FFFF);
        cmp("b_coll_sat", 32'(b_cnt), 32'h0000FFFF);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            v = mk(1'b0, 1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0, 1'b0, 0, 0, 0);
            v.rst  = ($urandom_range(0, 99) == 0);
            v.csb0 = ($urandom_range(0, 3) == 0);
            v.web0 = 1'($urandom_range(0, 1));
            v.wm   = 4'($urandom);
            v.d0   = $urandom;
            v.csb1 = ($urandom_range(0, 3) == 0);
            v.a0   = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(1000, 1023))
                                                   : 10'($urandom_range(0, 999));
            v.a1   = ($urandom_range(0, 3) == 0) ? v.a0
                   : (($urandom_range(0, 15) == 0) ? 10'($urandom_range(1000, 1023))
                                                    : 10'($urandom_range(0, 999)));
            if (!v.csb0 && !v.web0 && v.wm != 4'd0 && !v.csb1 && v.a0 == v.a1 && int'(v.a0) >= DEPTH)
                v.csb1 = 1'b1;
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
